fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/params_pkg.sv | 20 ++
 rtl/fetch_ibuf.sv | 63 ++++++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared types and default widths for the fetch stage.
package params_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned IBUF_DEPTH_DEF = 2;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DRAIN     = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: small synchronous FIFO with flush and occupancy count.
module fetch_ibuf
  import params_pkg::*;
#(
  parameter int unsigned DEPTH = IBUF_DEPTH_DEF,
  parameter type entry_t = ibuf_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; flush empties the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding decode
// through a small buffer, with redirect/flush handling.
// Optional FETCH_STATS_EN adds saturating fetch/stall/flush counters.
module fetch_stage
  import params_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH  = ADDR_W,
  parameter int unsigned             INSTR_WIDTH = INSTR_W,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int unsigned             IBUF_DEPTH  = IBUF_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   stall_fetch_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   dec_valid_o,
  output logic [INSTR_WIDTH-1:0] dec_instr_o,
  output logic [ADDR_WIDTH-1:0]  dec_pc_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched_o,
  output logic [31:0]            stat_stall_cycles_o,
  output logic [31:0]            stat_flushes_o
`endif
);

  localparam int unsigned CNT_W = $clog2(IBUF_DEPTH) + 1;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]      ibuf_count;
  logic                  slot_free;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic                  flush;
  ibuf_entry_t           push_entry;
  ibuf_entry_t           head;

  assign slot_free   = ibuf_count < CNT_W'(IBUF_DEPTH);
  assign imem_req_o  = rst_ni && (state_q == IDLE) && slot_free && !redirect_i;
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign dec_valid_o = (ibuf_count != '0) && !redirect_i;
  assign pop         = dec_valid_o && !stall_fetch_i;
  assign dec_instr_o = INSTR_WIDTH'(head.instr);
  assign dec_pc_o    = ADDR_WIDTH'(head.pc);
  assign push_entry  = '{instr: INSTR_W'(imem_rdata_i), pc: ADDR_W'(req_pc_q)};

  // State, fetch PC and in-flight request PC registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Next-state: redirect wins; an orphaned in-flight response is drained.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    if (redirect_i) begin
      flush = 1'b1;
      pc_d  = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      case (state_q)
        IDLE:      state_d = grant ? DRAIN : IDLE;
        WAIT_RESP: state_d = imem_rvalid_i ? IDLE : DRAIN;
        DRAIN:     state_d = imem_rvalid_i ? IDLE : DRAIN;
        default:   state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_d  = WAIT_RESP;
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
          end
        end
        WAIT_RESP: begin
          if (imem_rvalid_i) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        DRAIN: begin
          if (imem_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_ibuf #(
    .DEPTH   (IBUF_DEPTH),
    .entry_t (ibuf_entry_t)
  ) u_ibuf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (ibuf_count)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] flushes_q;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetched_q      <= '0;
      stall_cycles_q <= '0;
      flushes_q      <= '0;
    end else begin
      if (push && (fetched_q != '1))                             fetched_q      <= fetched_q + 32'd1;
      if (dec_valid_o && stall_fetch_i && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (redirect_i && (flushes_q != '1))                       flushes_q      <= flushes_q + 32'd1;
    end
  end

  assign stat_fetched_o      = fetched_q;
  assign stat_stall_cycles_o = stall_cycles_q;
  assign stat_flushes_o      = flushes_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model plus directed scenarios.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          DEPTH    = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_stall_cycles, stat_flushes;
`endif

  fetch_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_fetch_i (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .dec_valid_o   (dec_valid),
    .dec_instr_o   (dec_instr),
    .dec_pc_o      (dec_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched_o      (stat_fetched),
    .stat_stall_cycles_o (stat_stall_cycles),
    .stat_flushes_o      (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;
  bit run     = 1'b1;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- behavioural model + compare ----------------
  ent_t        m_q[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  logic [31:0] pop_pcs[$];
  int          pop_cyc[$];

  always @(negedge clk) begin
    bit exp_req, exp_v;
    if (!rst_n) begin
      m_q.delete();
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_pc    = RESET_PC;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      check("rst_dec_instr", dec_instr, 32'd0);
      check("rst_dec_pc", dec_pc, 32'd0);
    end else if (run) begin
      exp_req = !m_out && (m_q.size() < DEPTH) && !redirect;
      exp_v   = (m_q.size() != 0) && !redirect;
      check("req", 32'(imem_req), 32'(exp_req));
      if (exp_req) check("addr", imem_addr, m_pc);
      check("dec_valid", 32'(dec_valid), 32'(exp_v));
      if (exp_v) begin
        check("dec_instr", dec_instr, m_q[0].instr);
        check("dec_pc", dec_pc, m_q[0].pc);
      end
      if (dec_valid && !stall) begin
        pop_pcs.push_back(dec_pc);
        pop_cyc.push_back(cyc_n);
      end
      if (redirect) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_out) begin
          if (imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
          else m_stale = 1'b1;
        end
      end else begin
        if (exp_v && !stall) void'(m_q.pop_front());
        if (m_out && imem_rvalid) begin
          if (!m_stale) m_q.push_back('{instr: imem_rdata, pc: m_req_pc});
          m_out   = 1'b0;
          m_stale = 1'b0;
        end
        if (exp_req && imem_gnt) begin
          m_out    = 1'b1;
          m_stale  = 1'b0;
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- memory responder / driver ----------------
  bit          g_fire;
  logic [31:0] g_addr;
  logic [31:0] gaddrs[$];
  bit          pend_v;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          resp_lat;
  logic        s_req, s_dv;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic cyc();
    @(negedge clk);
    g_fire  = imem_req && imem_gnt;
    g_addr  = imem_addr;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_dv    = dec_valid;
    s_pc    = dec_pc;
    s_instr = dec_instr;
    if (g_fire) gaddrs.push_back(g_addr);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (g_fire) begin
      pend_v    = 1'b1;
      pend_cnt  = resp_lat;
      pend_addr = g_addr;
    end
    if (pend_v) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rdata_of(pend_addr);
        pend_v      = 1'b0;
      end
    end
  endtask

  task automatic wait_grant(input string name, output logic [31:0] a);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!g_fire && n < 40);
    if (!g_fire) begin
      n_total++;
      $display("FAIL %s: no grant within 40 cycles", name);
    end
    a = g_addr;
  endtask

  initial begin
    logic [31:0] a;
    int base, gbase;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    pend_v = 1'b0; pend_cnt = 0; pend_addr = '0; resp_lat = 1;

    // Reset, then back-to-back fetches with immediate grant and 1-cycle response
    repeat (3) cyc();
    rst_n = 1'b1;
    repeat (7) cyc();
    check("seq_grant_count", 32'(gaddrs.size() >= 3), 32'd1);
    check("seq_addr0", gaddrs[0], 32'h0000_1000);
    check("seq_addr1", gaddrs[1], 32'h0000_1004);
    check("seq_addr2", gaddrs[2], 32'h0000_1008);
    check("seq_pop0", pop_pcs[0], 32'h0000_1000);
    check("seq_pop1", pop_pcs[1], 32'h0000_1004);

    // Stall for 10 cycles right after redirect to 0x3000: buffer fills, request stops
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3000;
    cyc();
    redirect = 1'b0;
    repeat (10) cyc();
    check("stall_req_low", 32'(s_req), 32'd0);
    check("stall_dec_valid", 32'(s_dv), 32'd1);
    check("stall_head_pc", s_pc, 32'h0000_3000);
    check("stall_head_instr", s_instr, rdata_of(32'h0000_3000));
    base  = pop_pcs.size();
    stall = 1'b0;
    repeat (4) cyc();
    check("stall_pop_count", 32'(pop_pcs.size() >= base + 2), 32'd1);
    check("stall_pop0", pop_pcs[base], 32'h0000_3000);
    check("stall_pop1", pop_pcs[base+1], 32'h0000_3004);
    check("stall_pop_consec", 32'(pop_cyc[base+1] - pop_cyc[base]), 32'd1);

    // Redirect while a response is still outstanding: stale data discarded
    resp_lat = 3;
    wait_grant("drain_setup", a);
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    cyc();
    redirect = 1'b0;
    resp_lat = 1;
    wait_grant("drain_next", a);
    check("drain_next_addr", a, 32'h0000_2000);
    cyc();
    cyc();
    check("drain_first_valid", 32'(s_dv), 32'd1);
    check("drain_first_pc", s_pc, 32'h0000_2000);
    check("drain_first_instr", s_instr, rdata_of(32'h0000_2000));

    // Redirect coincident with response: no push, low address bits ignored
    wait_grant("coinc_setup", a);
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    cyc();
    redirect = 1'b0;
    cyc();
    check("coinc_dec_valid", 32'(s_dv), 32'd0);
    check("coinc_req", 32'(s_req), 32'd1);
    check("coinc_addr", s_addr, 32'h0000_4000);

    // Wrap at top of address space; grant withheld keeps request stable
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("hold_req", 32'(s_req), 32'd1);
      check("hold_addr", s_addr, 32'hFFFF_FFFC);
    end
    imem_gnt = 1'b1;
    wait_grant("wrap_g0", a);
    check("wrap_addr0", a, 32'hFFFF_FFFC);
    wait_grant("wrap_g1", a);
    check("wrap_addr1", a, 32'h0000_0000);

    // Reset while a request is in flight: late response must be ignored
    resp_lat = 2;
    wait_grant("rst_mid_setup", a);
    gbase = gaddrs.size();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    resp_lat = 1;
    base = pop_pcs.size();
    repeat (6) cyc();
    check("rst_mid_grant", gaddrs[gbase], 32'h0000_1000);
    check("rst_mid_pop_count", 32'(pop_pcs.size() > base), 32'd1);
    check("rst_mid_pop0", pop_pcs[base], 32'h0000_1000);

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
